regfile_wb_arbiter: RTL

- Sequences the single write port of the 32-entry integer register file.
- After reset it runs an init walk that writes every architectural register x1..x31: x2 gets the stack-pointer value, all others get zero.
- After the walk it shares the write port between two writeback requesters (A: ALU/execute, B: load/memory) using valid/ready handshakes and round-robin arbitration.
- Its outputs drive the register file's rd, write-data and write-enable inputs directly.

---
 rtl/regfile_wb_arbiter_if.sv | 19 +
 rtl/regfile_wb_arbiter.sv | 80 ++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request/ready bundle for the two requesters.
interface regfile_wb_arbiter_if #(parameter int DWIDTH = 32);
  logic              a_valid_i;
  logic [4:0]        a_rd_i;
  logic [DWIDTH-1:0] a_data_i;
  logic              a_ready_o;
  logic              b_valid_i;
  logic [4:0]        b_rd_i;
  logic [DWIDTH-1:0] b_data_i;
  logic              b_ready_o;
  modport slave (
    input  a_valid_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
    output a_ready_o, b_ready_o
  );
  modport master (
    output a_valid_i, a_rd_i, a_data_i, b_valid_i, b_rd_i, b_data_i,
    input  a_ready_o, b_ready_o
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: register-file write-port sequencer (init walk, then round-robin writeback).
module regfile_wb_arbiter #(
  parameter int                DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] SP_INIT     = 32'h7FFFFFFC,
  parameter bit                ENABLE_INIT = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wb_arbiter_if.slave      wb,
  output logic [4:0]               rd_o,
  output logic [DWIDTH-1:0]        datawb_o,
  output logic                     regwren_o,
  output logic                     init_done_o
);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic [4:0]        rd_q, rd_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              done_q, done_d;
  logic              gnt_a, gnt_b;
  // rr_q=0 favours A on contention, rr_q=1 favours B
  assign gnt_a = (state_q == RUN) && wb.a_valid_i && (!wb.b_valid_i || !rr_q);
  assign gnt_b = (state_q == RUN) && wb.b_valid_i && (!wb.a_valid_i || rr_q);
  // ready is masked while reset is asserted so no requester sees a false accept
  assign wb.a_ready_o = rst && gnt_a;
  assign wb.b_ready_o = rst && gnt_b;
  assign rd_o        = rd_q;
  assign datawb_o    = data_q;
  assign regwren_o   = wren_q;
  assign init_done_o = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    rd_d    = rd_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    done_d  = done_q;
    if (state_q == INIT) begin
      rd_d    = cnt_q;
      data_d  = (cnt_q == 5'd2) ? SP_INIT : '0;
      wren_d  = 1'b1;
      cnt_d   = cnt_q + 5'd1;
      state_d = (cnt_q == 5'd31) ? RUN : INIT;
      done_d  = (cnt_q == 5'd31);
    end else if (gnt_a) begin
      rd_d   = wb.a_rd_i;
      data_d = wb.a_data_i;
      wren_d = |wb.a_rd_i;
      rr_d   = 1'b1;
    end else if (gnt_b) begin
      rd_d   = wb.b_rd_i;
      data_d = wb.b_data_i;
      wren_d = |wb.b_rd_i;
      rr_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ENABLE_INIT ? INIT : RUN;
      cnt_q   <= 5'd1;
      rr_q    <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      done_q  <= !ENABLE_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      done_q  <= done_d;
    end
  end
endmodule
